// File: rtl/wisc_pkg.sv
// Shared opcodes, condition codes, flag bit positions and branch FSM states.
package wisc_pkg;

    localparam logic [3:0] OP_B  = 4'hC;
    localparam logic [3:0] OP_BR = 4'hD;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_UN = 3'b111;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REDIR = 2'd2
    } state_t;

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Condition-code evaluator: decides taken from the 3-bit code and {N,Z,V}.
module cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken_c
);

    logic n;
    logic z;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    // Condition table lookup
    always_comb begin
        taken_c = 1'b0;
        case (ccc)
            CC_NE:   taken_c = ~z;
            CC_EQ:   taken_c = z;
            CC_GT:   taken_c = ~z & ~n;
            CC_LT:   taken_c = n;
            CC_GE:   taken_c = z | (~z & ~n);
            CC_LE:   taken_c = n | z;
            CC_OV:   taken_c = v;
            CC_UN:   taken_c = 1'b1;
            default: taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// ID-stage branch resolver: condition check, target compute, registered
// redirect handshake to fetch, BR hazard stall and saturating perf counters.
module branch_unit
    import wisc_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [3:0]        opcode,
    input  logic [2:0]        ccc,
    input  logic [8:0]        imm9,
    input  logic [ADDR_W-1:0] pc_plus2,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              rs_hazard,
    input  logic [2:0]        flags,
    output logic              stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam int unsigned SEXT_W = ADDR_W - 10;

    state_t            state;
    state_t            state_next;
    logic              is_br;
    logic              is_reg_br;
    logic              taken_c;
    logic              resolve;
    logic [ADDR_W-1:0] target;

    assign is_br     = instr_valid & ((opcode == OP_B) | (opcode == OP_BR));
    assign is_reg_br = opcode == OP_BR;

    cond_eval u_cond_eval (
        .ccc     (ccc),
        .flags   (flags),
        .taken_c (taken_c)
    );

    // Target: register value for BR, pc_plus2 plus sign-extended word offset for B (wraps)
    always_comb begin
        target = rs_data;
        if (!is_reg_br) begin
            target = pc_plus2 + {{SEXT_W{imm9[8]}}, imm9, 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, stall/flush and resolve strobe
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        flush      = 1'b0;
        resolve    = 1'b0;
        case (state)
            IDLE: begin
                if (is_br) begin
                    if (is_reg_br && rs_hazard) begin
                        stall      = 1'b1;
                        state_next = WAIT;
                    end else begin
                        resolve = 1'b1;
                        if (taken_c) begin
                            state_next = REDIR;
                        end
                    end
                end
            end
            WAIT: begin
                if (rs_hazard) begin
                    stall = 1'b1;
                end else begin
                    resolve    = 1'b1;
                    state_next = taken_c ? REDIR : IDLE;
                end
            end
            REDIR: begin
                stall = ~redirect_ready;
                flush = redirect_ready & ~rst;
                if (redirect_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Redirect payload and handshake; payload held until fetch accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (resolve && taken_c) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
        end else if (state == REDIR && redirect_ready) begin
            redirect_valid <= 1'b0;
        end
    end

    // Saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (resolve) begin
            if (br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (taken_c && taken_count != '1) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized
// traffic against a cycle-level reference model. A second instance with
// 3-bit counters shares all stimulus to exercise counter saturation.
module tb_branch_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] pc_plus2;
    logic [15:0] rs_data;
    logic        rs_hazard;
    logic [2:0]  flags;
    logic        redirect_ready;

    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    logic        stall_s;
    logic        flush_s;
    logic        redirect_valid_s;
    logic [15:0] redirect_pc_s;
    logic [2:0]  br_count_s;
    logic [2:0]  taken_count_s;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_pend;
    bit          m_wait;
    logic [15:0] m_pc;
    int          m_br;
    int          m_tk;

    // expected outputs for the current cycle
    logic        e_stall;
    logic        e_flush;
    logic        e_rv;
    logic [15:0] e_pc;
    logic [15:0] e_br;
    logic [15:0] e_tk;
    logic [2:0]  e_br_s;
    logic [2:0]  e_tk_s;

    branch_unit #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .opcode         (opcode),
        .ccc            (ccc),
        .imm9           (imm9),
        .pc_plus2       (pc_plus2),
        .rs_data        (rs_data),
        .rs_hazard      (rs_hazard),
        .flags          (flags),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .br_count       (br_count),
        .taken_count    (taken_count)
    );

    branch_unit #(.ADDR_W(16), .CNT_W(3)) dut_s (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .opcode         (opcode),
        .ccc            (ccc),
        .imm9           (imm9),
        .pc_plus2       (pc_plus2),
        .rs_data        (rs_data),
        .rs_hazard      (rs_hazard),
        .flags          (flags),
        .stall          (stall_s),
        .flush          (flush_s),
        .redirect_valid (redirect_valid_s),
        .redirect_pc    (redirect_pc_s),
        .redirect_ready (redirect_ready),
        .br_count       (br_count_s),
        .taken_count    (taken_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition rules from the ISA table, written as plain boolean logic
    function automatic bit ref_taken(input logic [2:0] c, input logic [2:0] f);
        bit n;
        bit z;
        bit v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] ref_target();
        int off;
        off = imm9[8] ? int'(imm9) - 512 : int'(imm9);
        if (opcode == 4'hD) return rs_data;
        return 16'(int'(pc_plus2) + 2 * off);
    endfunction

    // Compute expected outputs for the inputs currently applied
    task automatic predict();
        #1;
        e_stall = 1'b0;
        e_flush = 1'b0;
        if (m_pend) begin
            e_stall = !redirect_ready;
            e_flush = redirect_ready && !rst;
        end else if (m_wait) begin
            e_stall = rs_hazard;
        end else if (instr_valid && opcode == 4'hD && rs_hazard) begin
            e_stall = 1'b1;
        end
        e_rv   = m_pend;
        e_pc   = m_pc;
        e_br   = (m_br > 65535) ? 16'hFFFF : 16'(m_br);
        e_tk   = (m_tk > 65535) ? 16'hFFFF : 16'(m_tk);
        e_br_s = (m_br > 7) ? 3'd7 : 3'(m_br);
        e_tk_s = (m_tk > 7) ? 3'd7 : 3'(m_tk);
    endtask

    // Update the model for the clock edge and advance to the next drive point
    task automatic advance();
        bit res;
        bit is_br;
        res   = 1'b0;
        is_br = instr_valid && (opcode == 4'hC || opcode == 4'hD);
        if (rst) begin
            m_pend = 1'b0;
            m_wait = 1'b0;
            m_pc   = 16'h0000;
            m_br   = 0;
            m_tk   = 0;
        end else if (m_pend) begin
            if (redirect_ready) m_pend = 1'b0;
        end else if (m_wait) begin
            if (!rs_hazard) begin
                res    = 1'b1;
                m_wait = 1'b0;
            end
        end else if (is_br) begin
            if (opcode == 4'hD && rs_hazard) m_wait = 1'b1;
            else res = 1'b1;
        end
        if (res) begin
            m_br = m_br + 1;
            if (ref_taken(ccc, flags)) begin
                m_tk   = m_tk + 1;
                m_pend = 1'b1;
                m_pc   = ref_target();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_valid    = 1'b0;
        opcode         = 4'h0;
        ccc            = 3'd0;
        imm9           = 9'd0;
        pc_plus2       = 16'h0000;
        rs_data        = 16'h0000;
        rs_hazard      = 1'b0;
        flags          = 3'd0;
        redirect_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic set_b(input logic [2:0] c, input logic [2:0] f,
                         input logic [15:0] pc, input logic [8:0] imm);
        instr_valid = 1'b1;
        opcode      = 4'hC;
        ccc         = c;
        flags       = f;
        pc_plus2    = pc;
        imm9        = imm;
    endtask

    task automatic test_reset();
        do_reset();
        predict();
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 16'h0000 || stall !== 1'b0 || flush !== 1'b0
            || br_count !== 16'h0000 || taken_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset: rv=%b pc=%h stall=%b flush=%b br=%h tk=%h, need all zero",
                     redirect_valid, redirect_pc, stall, flush, br_count, taken_count);
        end
    endtask

    task automatic test_b_taken();
        do_reset();
        set_b(3'b001, 3'b010, 16'h0010, 9'h004);
        predict();
        checks++;
        if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_taken_resolve: stall=%b rv=%b, need 0 0", stall, redirect_valid);
        end
        advance();
        instr_valid = 1'b0;
        predict();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0018 || taken_count !== 16'd1
            || stall !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL b_taken_redirect: rv=%b pc=%h tk=%0d stall=%b flush=%b, need 1 0018 1 1 0",
                     redirect_valid, redirect_pc, taken_count, stall, flush);
        end
        redirect_ready = 1'b1;
        predict();
        checks++;
        if (flush !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL b_taken_accept: flush=%b stall=%b, need 1 0", flush, stall);
        end
        advance();
        redirect_ready = 1'b0;
        predict();
        checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL b_taken_after: rv=%b flush=%b, need 0 0", redirect_valid, flush);
        end
    endtask

    task automatic test_b_not_taken();
        do_reset();
        set_b(3'b001, 3'b000, 16'h0010, 9'h004);
        predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b_nt_stall: stall=%b, need 0", stall);
        end
        advance();
        instr_valid = 1'b0;
        predict();
        checks++;
        if (redirect_valid !== 1'b0 || br_count !== 16'd1 || taken_count !== 16'd0) begin
            errors++;
            $display("FAIL b_nt_counts: rv=%b br=%0d tk=%0d, need 0 1 0",
                     redirect_valid, br_count, taken_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_b(3'b111, 3'b000, 16'hFFFE, 9'h002);
        advance();
        instr_valid    = 1'b0;
        redirect_ready = 1'b1;
        predict();
        checks++;
        if (redirect_pc !== 16'h0002) begin
            errors++;
            $display("FAIL wrap_up: pc=%h, need 0002", redirect_pc);
        end
        advance();
        redirect_ready = 1'b0;
        set_b(3'b111, 3'b000, 16'h0004, 9'h1FE);
        advance();
        instr_valid    = 1'b0;
        redirect_ready = 1'b1;
        predict();
        checks++;
        if (redirect_pc !== 16'h0000 || redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_neg: pc=%h rv=%b, need 0000 1", redirect_pc, redirect_valid);
        end
        advance();
        redirect_ready = 1'b0;
    endtask

    task automatic test_br_hazard();
        do_reset();
        instr_valid = 1'b1;
        opcode      = 4'hD;
        ccc         = 3'b111;
        rs_hazard   = 1'b1;
        rs_data     = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            predict();
            checks++;
            if (stall !== 1'b1 || br_count !== 16'd0) begin
                errors++;
                $display("FAIL br_hazard_stall%0d: stall=%b br=%0d, need 1 0", i, stall, br_count);
            end
            advance();
        end
        rs_hazard = 1'b0;
        rs_data   = 16'h1234;
        predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL br_hazard_release: stall=%b, need 0", stall);
        end
        advance();
        instr_valid = 1'b0;
        predict();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h1234 || br_count !== 16'd1) begin
            errors++;
            $display("FAIL br_hazard_redirect: rv=%b pc=%h br=%0d, need 1 1234 1",
                     redirect_valid, redirect_pc, br_count);
        end
        redirect_ready = 1'b1;
        advance();
        redirect_ready = 1'b0;
        // hazard on a B is ignored
        set_b(3'b000, 3'b000, 16'h0100, 9'h010);
        rs_hazard = 1'b1;
        predict();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b_hazard_ignored: stall=%b, need 0", stall);
        end
        advance();
        instr_valid = 1'b0;
        rs_hazard   = 1'b0;
        predict();
        checks++;
        if (br_count !== 16'd2 || redirect_pc !== 16'h0120) begin
            errors++;
            $display("FAIL b_hazard_resolve: br=%0d pc=%h, need 2 0120", br_count, redirect_pc);
        end
        redirect_ready = 1'b1;
        advance();
        redirect_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        do_reset();
        set_b(3'b111, 3'b000, 16'h2000, 9'h0FF);
        advance();
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            predict();
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 16'h21FE || stall !== 1'b1 || flush !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: rv=%b pc=%h stall=%b flush=%b, need 1 21fe 1 0",
                         i, redirect_valid, redirect_pc, stall, flush);
            end
            advance();
        end
        redirect_ready = 1'b1;
        predict();
        checks++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: flush=%b, need 1", flush);
        end
        advance();
        redirect_ready = 1'b0;
        // reset while a redirect is pending
        set_b(3'b111, 3'b000, 16'h3000, 9'h002);
        advance();
        instr_valid    = 1'b0;
        rst            = 1'b1;
        redirect_ready = 1'b1;
        predict();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL redir_rst_flush: flush=%b, need 0", flush);
        end
        advance();
        rst            = 1'b0;
        redirect_ready = 1'b0;
        predict();
        checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0 || redirect_pc !== 16'h0000 || br_count !== 16'd0) begin
            errors++;
            $display("FAIL redir_rst_state: rv=%b flush=%b pc=%h br=%0d, need 0 0 0000 0",
                     redirect_valid, flush, redirect_pc, br_count);
        end
    endtask

    task automatic test_cond_sweep();
        int tk;
        tk = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                set_b(3'(c), 3'(f), 16'h0100, 9'($urandom_range(0, 511)));
                advance();
                instr_valid = 1'b0;
                predict();
                checks++;
                if (redirect_valid !== ref_taken(3'(c), 3'(f)) || redirect_pc !== e_pc) begin
                    errors++;
                    $display("FAIL cond ccc=%0d flags=%03b: rv=%b pc=%h, need %b %h",
                             c, f, redirect_valid, redirect_pc, ref_taken(3'(c), 3'(f)), e_pc);
                end
                if (ref_taken(3'(c), 3'(f))) tk++;
                redirect_ready = 1'b1;
                advance();
                redirect_ready = 1'b0;
            end
        end
        predict();
        checks++;
        if (br_count !== 16'd64 || taken_count !== 16'(tk) || br_count_s !== 3'd7 || taken_count_s !== 3'd7) begin
            errors++;
            $display("FAIL sweep_counts: br=%0d tk=%0d br_s=%0d tk_s=%0d, need 64 %0d 7 7",
                     br_count, taken_count, br_count_s, taken_count_s, tk);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_b(3'b111, 3'b000, 16'h0040, 9'h001);
            advance();
            instr_valid    = 1'b0;
            redirect_ready = 1'b1;
            predict();
            checks++;
            if (br_count_s !== e_br_s || taken_count_s !== e_tk_s || br_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL sat%0d: br_s=%0d tk_s=%0d br=%0d, need %0d %0d %0d",
                         i, br_count_s, taken_count_s, br_count, e_br_s, e_tk_s, i + 1);
            end
            advance();
            redirect_ready = 1'b0;
        end
        predict();
        checks++;
        if (br_count_s !== 3'd7 || taken_count_s !== 3'd7) begin
            errors++;
            $display("FAIL sat_final: br_s=%0d tk_s=%0d, need 7 7", br_count_s, taken_count_s);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            redirect_ready = ($urandom_range(0, 2) != 0);
            rs_hazard      = ($urandom_range(0, 2) == 0);
            flags          = 3'($urandom_range(0, 7));
            if (!m_wait && !m_pend) begin
                instr_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0, 1:    opcode = 4'hC;
                    2:       opcode = 4'hD;
                    default: opcode = 4'($urandom_range(0, 15));
                endcase
                ccc      = 3'($urandom_range(0, 7));
                imm9     = 9'($urandom_range(0, 511));
                pc_plus2 = 16'($urandom);
                rs_data  = 16'($urandom);
            end else if (m_wait && rs_hazard) begin
                rs_data = 16'($urandom);
            end
            predict();
            checks++;
            if (stall !== e_stall || flush !== e_flush || redirect_valid !== e_rv || redirect_pc !== e_pc
                || br_count !== e_br || taken_count !== e_tk || br_count_s !== e_br_s || taken_count_s !== e_tk_s) begin
                errors++;
                $display("FAIL random%0d: stall=%b flush=%b rv=%b pc=%h br=%0d tk=%0d brs=%0d tks=%0d, need %b %b %b %h %0d %0d %0d %0d",
                         i, stall, flush, redirect_valid, redirect_pc, br_count, taken_count,
                         br_count_s, taken_count_s, e_stall, e_flush, e_rv, e_pc, e_br, e_tk, e_br_s, e_tk_s);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        // taken B accepted immediately, then a new B resolves the cycle after
        set_b(3'b111, 3'b000, 16'h1000, 9'h008);
        advance();
        instr_valid    = 1'b0;
        redirect_ready = 1'b1;
        advance();
        redirect_ready = 1'b0;
        set_b(3'b110, 3'b001, 16'h2000, 9'h010);
        predict();
        checks++;
        if (stall !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: stall=%b rv=%b, need 0 0", stall, redirect_valid);
        end
        advance();
        instr_valid = 1'b0;
        predict();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h2020 || br_count !== 16'd2 || taken_count !== 16'd2) begin
            errors++;
            $display("FAIL b2b_second: rv=%b pc=%h br=%0d tk=%0d, need 1 2020 2 2",
                     redirect_valid, redirect_pc, br_count, taken_count);
        end
        redirect_ready = 1'b1;
        advance();
        redirect_ready = 1'b0;
    endtask

    initial begin
        m_pend = 1'b0;
        m_wait = 1'b0;
        m_pc   = 16'h0000;
        m_br   = 0;
        m_tk   = 0;
        rst    = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_b_taken();
        test_b_not_taken();
        test_wrap();
        test_br_hazard();
        test_redirect_hold();
        test_cond_sweep();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
